// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, payload width and default
// bit period used by both the receiver and the paired transmitter.
package uart_pkg;

  localparam int UART_DATA_BITS    = 8;
  localparam int UART_CLKS_PER_BIT = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } uart_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit,
// with a selectable reset value for the idle level of the line.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: oversampled start-bit detection, mid-bit sampling,
// one-cycle valid / frame_err strobes and a break hold-off state.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int DATA_BITS    = UART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  logic rx_s;

  sync_2ff #(
    .RST_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  uart_state_e          state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    idx_d   = idx_q;
    sh_d    = sh_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    busy_d  = busy_q;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!rx_s) begin
          state_d = ST_START;
          busy_d  = 1'b1;
        end
      end
      ST_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d = ST_DATA;
            idx_d   = '0;
          end else begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end
        end
      end
      ST_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          // LSB arrives first, so shift in from the top
          sh_d  = {rx_s, sh_q[DATA_BITS-1:1]};
          if (idx_q == IDX_LAST) begin
            state_d = ST_STOP;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      ST_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            data_d  = sh_q;
            valid_d = 1'b1;
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end else begin
            ferr_d  = 1'b1;
            state_d = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        cnt_d = '0;
        if (rx_s) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      busy_q  <= busy_d;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed/random bench for uart_receiver: N=4 instance for timing and
// error cases, N=16 instance fed by a behavioural transmitter.
module tb_uart_receiver;

  logic       clk;
  logic       rst;
  logic       rx4, rx16;
  logic [7:0] data4, data16;
  logic       valid4, valid16;
  logic       ferr4, ferr16;
  logic       busy4, busy16;

  uart_receiver #(.CLKS_PER_BIT(4)) u4 (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx4),
    .data      (data4),
    .valid     (valid4),
    .frame_err (ferr4),
    .busy      (busy4)
  );

  uart_receiver #(.CLKS_PER_BIT(16)) u16 (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx16),
    .data      (data16),
    .valid     (valid16),
    .frame_err (ferr16),
    .busy      (busy16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int         vcyc4[$];
  logic [7:0] vdat4[$];
  int         vcyc16[$];
  logic [7:0] vdat16[$];
  int         fcnt4 = 0, fcnt16 = 0, bcnt4 = 0, ovl = 0;

  always @(negedge clk) begin
    if (valid4) begin
      vcyc4.push_back(cyc);
      vdat4.push_back(data4);
    end
    if (valid16) begin
      vcyc16.push_back(cyc);
      vdat16.push_back(data16);
    end
    if (ferr4) fcnt4++;
    if (ferr16) fcnt16++;
    if (busy4) bcnt4++;
    if ((valid4 && ferr4) || (valid16 && ferr16)) ovl++;
  end

  int passed = 0, total = 0, fails = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Latency from the first capturing edge to the strobe cycle.
  function automatic int strobe_lat(input int n);
    return 2 + n / 2 + 9 * n;
  endfunction

  task automatic drive(input bit lb, input logic v, input int cycles);
    if (lb) rx16 = v;
    else rx4 = v;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input bit lb, input int n,
                            input logic [7:0] b, input logic stop);
    drive(lb, 1'b0, n);
    for (int i = 0; i < 8; i++) drive(lb, b[i], n);
    drive(lb, stop, n);
  endtask

  task automatic clear_mon();
    vcyc4.delete();
    vdat4.delete();
    vcyc16.delete();
    vdat16.delete();
    fcnt4 = 0;
    fcnt16 = 0;
    bcnt4 = 0;
  endtask

  logic [7:0] exp_q[$];
  logic [7:0] lb_bytes[4] = '{8'h00, 8'hFF, 8'h77, 8'h81};
  logic [7:0] prev, b;
  int         e0;

  initial begin
    rst  = 1'b0;
    rx4  = 1'b1;
    rx16 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", data4, 8'h00);
    check("rst_valid", valid4, 1'b0);
    check("rst_ferr", ferr4, 1'b0);
    check("rst_busy", busy4, 1'b0);
    check("rst_busy16", busy16, 1'b0);
    rst = 1'b1;
    drive(0, 1'b1, 5);

    clear_mon();
    e0 = cyc + 1;
    send_frame(0, 4, 8'h77, 1'b1);
    drive(0, 1'b1, 6);
    check("single_cnt", vdat4.size(), 1);
    check("single_data", vdat4[0], 8'h77);
    check("single_time", vcyc4[0] - e0, strobe_lat(4));
    check("single_ferr", fcnt4, 0);

    clear_mon();
    send_frame(0, 4, 8'h77, 1'b1);
    send_frame(0, 4, 8'h81, 1'b1);
    drive(0, 1'b1, 6);
    check("b2b_cnt", vdat4.size(), 2);
    check("b2b_d0", vdat4[0], 8'h77);
    check("b2b_d1", vdat4[1], 8'h81);
    check("b2b_gap", vcyc4[1] - vcyc4[0], 40);

    clear_mon();
    drive(0, 1'b0, 1);
    drive(0, 1'b1, 10);
    check("glitch_valid", vdat4.size(), 0);
    check("glitch_busy", (bcnt4 > 0 && bcnt4 <= 3), 1'b1);

    clear_mon();
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      send_frame(0, 4, b, 1'b1);
    end
    drive(0, 1'b1, 6);
    check("rand_cnt", vdat4.size(), 3);
    for (int i = 0; i < 3; i++) check("rand_data", vdat4[i], exp_q[i]);
    prev = exp_q[2];

    clear_mon();
    drive(0, 1'b0, 4);
    for (int i = 0; i < 8; i++) drive(0, 1'(8'h55 >> i), 4);
    drive(0, 1'b0, 4 + 50);
    check("ferr_cnt", fcnt4, 1);
    check("ferr_novalid", vdat4.size(), 0);
    check("ferr_data", data4, prev);
    check("ferr_busy_held", busy4, 1'b1);
    drive(0, 1'b1, 4);
    check("ferr_busy_rel", busy4, 1'b0);

    clear_mon();
    drive(0, 1'b0, 4);
    for (int i = 0; i < 3; i++) drive(0, 1'(8'h3C >> i), 4);
    drive(0, 1'b1, 2);
    rst = 1'b0;
    #1;
    check("mrst_data", data4, 8'h00);
    check("mrst_busy", busy4, 1'b0);
    check("mrst_valid", valid4, 1'b0);
    check("mrst_ferr", ferr4, 1'b0);
    rx4 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    drive(0, 1'b1, 3);
    check("mrst_none", vdat4.size() + fcnt4, 0);
    send_frame(0, 4, 8'hA5, 1'b1);
    drive(0, 1'b1, 6);
    check("mrst_cnt", vdat4.size(), 1);
    check("mrst_a5", vdat4[0], 8'hA5);

    clear_mon();
    e0 = cyc + 1;
    for (int i = 0; i < 4; i++) send_frame(1, 16, lb_bytes[i], 1'b1);
    drive(1, 1'b1, 20);
    check("lb_cnt", vdat16.size(), 4);
    for (int i = 0; i < 4; i++) check("lb_data", vdat16[i], lb_bytes[i]);
    check("lb_time", vcyc16[0] - e0, strobe_lat(16));
    check("lb_ferr", fcnt16, 0);
    check("no_overlap", ovl, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
